// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and defaults for the data-memory responder.
// Holds the FSM state enum, default WIDTH/AW/LATENCY values and the latency
// counter width. Optional byte-strobe support is selected with DMEM_WSTRB_EN.
package dmem_pkg;

  localparam int unsigned DEF_WIDTH   = 32;
  localparam int unsigned DEF_AW      = 8;
  localparam int unsigned DEF_LATENCY = 2;
  localparam int unsigned CNT_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: 2^AW x WIDTH word storage.
// Ports: clk; i_we write enable; i_addr word address; i_wdata write data;
//        i_bmask per-bit write mask (1 = write); o_rdata async read of i_addr.
// Contents are never reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned AW    = DEF_AW
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [WIDTH-1:0] i_bmask,
  output logic [WIDTH-1:0] o_rdata
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Masked-off bits keep their previous contents.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= (r_mem[i_addr] & ~i_bmask) | (i_wdata & i_bmask);
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data-memory responder with valid/ready
// request and response channels.
// Ports: clk, rst (async, active-high); req_valid/req_ready/req_we/req_addr/
//        req_wdata request channel; resp_valid/resp_ready/resp_rdata response
//        channel. With DMEM_WSTRB_EN defined, req_wstrb adds per-byte store
//        enables; otherwise stores write the full word.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned AW      = DEF_AW,
  parameter int unsigned LATENCY = DEF_LATENCY
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [WIDTH-1:0]   req_addr,
  input  logic [WIDTH-1:0]   req_wdata,
`ifdef DMEM_WSTRB_EN
  input  logic [WIDTH/8-1:0] req_wstrb,
`endif
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [WIDTH-1:0]   resp_rdata
);

  localparam int unsigned SW = WIDTH / 8;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_we;
  logic [AW-1:0]    r_addr;
  logic [WIDTH-1:0] r_wdata;
  logic             r_req_ready;
  logic             r_resp_valid;
  logic [WIDTH-1:0] r_resp_rdata;

  logic [WIDTH-1:0] w_bmask;
  logic [WIDTH-1:0] w_rdata;
  logic [WIDTH-1:0] w_merged;
  logic             w_access;
  logic             w_array_we;
  logic             w_unused_addr;

  // Only the word-select bits of the byte address matter.
  assign w_unused_addr = ^{req_addr[WIDTH-1:AW+2], req_addr[1:0]};

`ifdef DMEM_WSTRB_EN
  logic [SW-1:0] r_wstrb;

  // Expand captured byte strobes to a bit mask.
  always_comb begin
    w_bmask = '0;
    for (int i = 0; i < int'(SW); i++) begin
      w_bmask[8*i +: 8] = {8{r_wstrb[i]}};
    end
  end
`else
  assign w_bmask = '1;
`endif

  assign w_access   = (r_state == ST_BUSY) && (r_cnt == '0);
  assign w_array_we = w_access && r_we;
  assign w_merged   = (w_rdata & ~w_bmask) | (r_wdata & w_bmask);

  dmem_array #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .i_we    (w_array_we),
    .i_addr  (r_addr),
    .i_wdata (r_wdata),
    .i_bmask (w_bmask),
    .o_rdata (w_rdata)
  );

  // Request capture, latency countdown and response hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
`ifdef DMEM_WSTRB_EN
      r_wstrb      <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_we        <= req_we;
            r_addr      <= req_addr[AW+1:2];
            r_wdata     <= req_wdata;
`ifdef DMEM_WSTRB_EN
            r_wstrb     <= req_wstrb;
`endif
            r_cnt       <= CNT_W'(LATENCY - 1);
            r_req_ready <= 1'b0;
            r_state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            // Stores report the word as it will be written.
            r_resp_rdata <= r_we ? w_merged : w_rdata;
            r_resp_valid <= 1'b1;
            r_state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_resp_valid <= 1'b0;
          r_req_ready  <= 1'b1;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed bench for dmem_responder with a response
// scoreboard and a reference word model.
module tb_dmem_responder;

  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;

  logic [31:0] model [256];
  logic [31:0] sb_q [$];
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  dmem_responder #(
    .WIDTH   (32),
    .AW      (8),
    .LATENCY (LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
`ifdef DMEM_WSTRB_EN
    .req_wstrb  (req_wstrb),
`endif
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
  endtask

  // Drive one request at a negedge, accept at the following posedge, then
  // scramble the request inputs. Returns at the negedge after acceptance.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input bit push);
    int          n;
    logic [7:0]  idx;
    logic [31:0] m;
    logic [31:0] e;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = strb;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = ~we;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_wstrb = ~strb;
    chk("busy_req_ready", 32'(req_ready), 32'd0);
    idx = addr[9:2];
`ifdef DMEM_WSTRB_EN
    m = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
`else
    m = 32'hFFFF_FFFF;
`endif
    if (we) begin
      e = (model[idx] & ~m) | (wdata & m);
      if (push) model[idx] = e;
    end else begin
      e = model[idx];
    end
    if (push) sb_q.push_back(e);
  endtask

  // Wait for the response, check latency and data, optionally hold
  // resp_ready low for 'hold' cycles (resp_ready must already be low then).
  task automatic get_resp(input int hold);
    int          n;
    logic [31:0] e;
    n = 0;
    while (!resp_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("resp_valid", 32'(resp_valid), 32'd1);
    chk("latency", 32'(n), 32'(LAT));
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk("resp_rdata", resp_rdata, e);
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold_valid", 32'(resp_valid), 32'd1);
        chk("hold_rdata", resp_rdata, e);
        chk("hold_req_ready", 32'(req_ready), 32'd0);
      end
    end else begin
      chk("scoreboard_nonempty", 32'd0, 32'd1);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("resp_done_valid", 32'(resp_valid), 32'd0);
    chk("resp_done_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    int n;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_wstrb  = '0;
    resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_state("reset");

    // Store then load.
    issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b1);
    get_resp(0);
    issue(1'b0, 32'h0000_0010, 32'h0, 4'hF, 1'b1);
    get_resp(0);

    // Back-pressure.
    resp_ready = 1'b0;
    issue(1'b0, 32'h0000_0010, 32'h0, 4'hF, 1'b1);
    get_resp(5);

    // Address wrap and ignored low / high bits.
    issue(1'b1, 32'h0000_0400, 32'h1111_1111, 4'hF, 1'b1);
    get_resp(0);
    issue(1'b0, 32'h0000_0000, 32'h0, 4'hF, 1'b1);
    get_resp(0);
    issue(1'b0, 32'h0000_0003, 32'h0, 4'hF, 1'b1);
    get_resp(0);
    issue(1'b0, 32'hFFFF_FC12, 32'h0, 4'hF, 1'b1);
    get_resp(0);

    // Read-after-write in back-to-back transactions.
    issue(1'b1, 32'h0000_0010, 32'hCAFE_F00D, 4'hF, 1'b1);
    get_resp(0);
    issue(1'b0, 32'h0000_0010, 32'h0, 4'hF, 1'b1);
    get_resp(0);

    // Reset in BUSY discards the pending store.
    issue(1'b1, 32'h0000_0020, 32'h1234_5678, 4'hF, 1'b1);
    get_resp(0);
    issue(1'b1, 32'h0000_0020, 32'h0000_0055, 4'hF, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_state("busy_reset");
    rst = 1'b0;
    @(negedge clk);
    issue(1'b0, 32'h0000_0020, 32'h0, 4'hF, 1'b1);
    get_resp(0);

    // Reset in RESP drops the response.
    resp_ready = 1'b0;
    issue(1'b0, 32'h0000_0010, 32'h0, 4'hF, 1'b0);
    n = 0;
    while (!resp_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("resp_before_reset", 32'(resp_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_state("resp_reset");
    rst = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    issue(1'b0, 32'h0000_0400, 32'h0, 4'hF, 1'b1);
    get_resp(0);

`ifdef DMEM_WSTRB_EN
    // Byte strobes merge with the old word.
    issue(1'b1, 32'h0000_0030, 32'h0000_0000, 4'hF, 1'b1);
    get_resp(0);
    issue(1'b1, 32'h0000_0030, 32'hAABB_CCDD, 4'b0101, 1'b1);
    get_resp(0);
    issue(1'b0, 32'h0000_0030, 32'h0, 4'hF, 1'b1);
    get_resp(0);
    chk("strobe_model", model[8'h0C], 32'h00BB_00DD);
`endif

    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
